// File: rtl/div_unit.sv
// Iterative RV32M divide/remainder unit: restoring division, one quotient bit per cycle.
// Divide-by-zero and signed overflow finish on a fast path one cycle after acceptance.
module div_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clock_i,
    input  logic            reset_ni,
    input  logic            start_i,
    input  logic [1:0]      op_i,
    input  logic [XLEN-1:0] rs1_data_i,
    input  logic [XLEN-1:0] rs2_data_i,
    input  logic [4:0]      rd_addr_i,
    input  logic            flush_i,
    output logic            busy_o,
    output logic            valid_o,
    output logic [XLEN-1:0] result_o,
    output logic [4:0]      rd_addr_o,
    output logic [1:0]      dbg_state_o
);

    // Handshake: start_i is taken at an edge only in IDLE or DONE (no flush_i);
    // busy_o is the stall back to the issuing stage, and valid_o is a single-cycle
    // write strobe with no back-pressure from writeback.

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    logic [1:0]      state;
    logic [CNT_W-1:0] cnt;
    logic            op_rem_q;
    logic            quot_neg_q;
    logic            rem_neg_q;
    logic [XLEN-1:0] dividend_q;
    logic [XLEN-1:0] divisor_q;
    logic [XLEN-1:0] rem_q;
    logic [XLEN-1:0] quot_q;
    logic [4:0]      rd_q;

    logic            is_signed;
    logic            a_neg;
    logic            b_neg;
    logic            div_zero;
    logic            ovf;
    logic [XLEN-1:0] a_mag;
    logic [XLEN-1:0] b_mag;
    logic [XLEN-1:0] fast_result;

    always_comb begin
        is_signed   = ~op_i[0];
        a_neg       = is_signed & rs1_data_i[XLEN-1];
        b_neg       = is_signed & rs2_data_i[XLEN-1];
        a_mag       = a_neg ? -rs1_data_i : rs1_data_i;
        b_mag       = b_neg ? -rs2_data_i : rs2_data_i;
        div_zero    = (rs2_data_i == '0);
        ovf         = is_signed && (rs1_data_i == INT_MIN) && (rs2_data_i == '1);
        fast_result = '0;
        if (div_zero)
            fast_result = op_i[1] ? rs1_data_i : '1;
        else if (ovf)
            fast_result = op_i[1] ? '0 : INT_MIN;
    end

    logic [XLEN:0]   rem_shift;
    logic [XLEN:0]   diff;
    logic            q_bit;
    logic [XLEN-1:0] rem_next;
    logic [XLEN-1:0] quot_next;
    logic [XLEN-1:0] quot_fix;
    logic [XLEN-1:0] rem_fix;
    logic [XLEN-1:0] final_result;

    // One restoring step; the top bit of the XLEN+1 wide difference is its sign.
    always_comb begin
        rem_shift    = {rem_q, dividend_q[XLEN-1]};
        diff         = rem_shift - {1'b0, divisor_q};
        q_bit        = ~diff[XLEN];
        rem_next     = q_bit ? diff[XLEN-1:0] : rem_shift[XLEN-1:0];
        quot_next    = {quot_q[XLEN-2:0], q_bit};
        quot_fix     = quot_neg_q ? -quot_next : quot_next;
        rem_fix      = rem_neg_q ? -rem_next : rem_next;
        final_result = op_rem_q ? rem_fix : quot_fix;
    end

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state      <= IDLE;
            cnt        <= '0;
            op_rem_q   <= 1'b0;
            quot_neg_q <= 1'b0;
            rem_neg_q  <= 1'b0;
            dividend_q <= '0;
            divisor_q  <= '0;
            rem_q      <= '0;
            quot_q     <= '0;
            rd_q       <= '0;
            result_o   <= '0;
            rd_addr_o  <= '0;
        end else if (flush_i) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start_i) begin
                        if (div_zero || ovf) begin
                            result_o  <= fast_result;
                            rd_addr_o <= rd_addr_i;
                            state     <= DONE;
                        end else begin
                            state      <= CALC;
                            cnt        <= CNT_W'(XLEN-1);
                            dividend_q <= a_mag;
                            divisor_q  <= b_mag;
                            rem_q      <= '0;
                            quot_q     <= '0;
                            op_rem_q   <= op_i[1];
                            quot_neg_q <= a_neg ^ b_neg;
                            rem_neg_q  <= a_neg;
                            rd_q       <= rd_addr_i;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                CALC: begin
                    rem_q      <= rem_next;
                    quot_q     <= quot_next;
                    dividend_q <= dividend_q << 1;
                    cnt        <= cnt - CNT_W'(1);
                    if (cnt == '0) begin
                        result_o  <= final_result;
                        rd_addr_o <= rd_q;
                        state     <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy_o      = (state == CALC);
    assign valid_o     = (state == DONE);
    assign dbg_state_o = state;

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
Iterative RV32M divide/remainder unit in the execute stage. Consumes the two source operands read from the register file and returns a result, destination index and one-cycle write strobe for the writeback path. Handles DIV, DIVU, REM and REMU. Uses restoring division at one quotient bit per cycle. Divide-by-zero and signed overflow complete on a fast path.

Parameters:
XLEN, 32, operand and result width
CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > XLEN

Ports:
clock_i  input  1  system clock, rising edge
reset_ni  input  1  asynchronous active-low reset
start_i  input  1  request; sampled only when the unit is idle or done
op_i  input  2  00 DIV, 01 DIVU, 10 REM, 11 REMU
rs1_data_i  input  XLEN  dividend
rs2_data_i  input  XLEN  divisor
rd_addr_i  input  5  destination register index
flush_i  input  1  synchronous abort of the in-flight operation
busy_o  output  1  high while iterating
valid_o  output  1  one-cycle strobe: result_o and rd_addr_o are valid, write enable for the register file
result_o  output  XLEN  quotient or remainder
rd_addr_o  output  5  destination index of the completed operation

Behaviour:
- Clock and reset:
  - One clock, clock_i.
  - Reset is asynchronous and active-low on reset_ni.
  - Reset forces state IDLE, busy_o=0, valid_o=0, result_o=0, rd_addr_o=0 and clears the counter and all internal registers.
  - Reset asserted mid-operation discards the operation; no valid_o follows.
- States:
  - IDLE: waiting for a request.
  - CALC: iterating.
  - DONE: valid_o=1 for exactly this one cycle.
- Acceptance: start_i is accepted at an edge only when the state is IDLE or DONE (back-to-back issue allowed). At acceptance the unit captures op_i, operands and rd_addr_i.
- Fast paths, taken at acceptance, go straight to DONE:
  - Divisor 0: quotient = all ones; remainder = dividend (both signed and unsigned).
  - Signed op with dividend 0x80000000 and divisor 0xFFFFFFFF: quotient = 0x80000000; remainder = 0.
  - Latency: valid_o is high in the cycle after the accepting edge.
- Normal path:
  - For signed ops, magnitudes are taken at acceptance.
  - The state machine enters CALC with counter = XLEN-1.
  - Each CALC edge performs one restoring step: shift the remainder left, bring in the next dividend MSB, trial-subtract the divisor magnitude, and set the quotient bit if the result is non-negative.
  - After XLEN steps the state goes to DONE.
  - Sign correction is applied before result_o is registered:
    - Quotient is negated when the operand signs differ.
    - Remainder takes the sign of the dividend.
  - REM/REMU select the remainder; DIV/DIVU select the quotient.
  - Latency: accepting edge E0, steps on E1..E32, DONE entered at E32. valid_o is high between E32 and E33 (XLEN cycles after acceptance).
- busy_o: equals (state==CALC); it is 0 in IDLE and DONE.
- Requests while busy: start_i while busy is ignored; it is neither queued nor flagged. The upstream stage stalls on busy_o.
- flush_i:
  - Any state returns to IDLE at the next edge and no valid_o is produced.
  - flush_i has priority over start_i in the same cycle, so that start is dropped.
  - flush_i in DONE suppresses nothing already emitted, because valid_o was already high that cycle.
- Output hold: result_o and rd_addr_o hold their last values until the next completion. They change only on the edge entering DONE.
- rd_addr_o = 0: completes normally with valid_o=1; the register file discards writes to x0.
- Arithmetic: all internal subtraction is XLEN+1 bits wide, and the sign of the trial difference decides the quotient bit. There is no multicycle or false-path constraint; all logic is single-cycle between flops.

Test Plan:
- DIVU 100/7, rd=5 -> busy_o high 32 cycles, valid_o once, result_o=14, rd_addr_o=5; REMU same operands -> 2.
- DIV 0xFFFFFFF9 (-7) / 2 -> 0xFFFFFFFD (-3); REM -> 0xFFFFFFFF (-1); DIV 7 / 0xFFFFFFFE -> 0xFFFFFFFD.
- DIVU 5/0 -> valid_o next cycle, result 0xFFFFFFFF, busy_o never high; REMU 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM -> 0.
- Start DIVU 1000/10; pulse start_i with other operands at cycle 5 -> ignored, result 100. Assert start_i in the DONE cycle -> second op accepted, no idle gap.
- flush_i at cycle 10 of an operation -> busy_o low next cycle, no valid_o, result_o unchanged. flush_i and start_i together -> nothing accepted.
- Drive reset_ni low asynchronously mid-CALC (between edges) -> outputs zero immediately, no valid_o after release; next DIVU 9/3 -> 3.
